// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring
// divide, one add/subtract per cycle through the borrowed shared ALU.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            alu_grant,
    output logic [3:0]      alu_func,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg, op_next;
    logic [XLEN-1:0]   hi_reg, hi_next;        // product high half / partial remainder
    logic [XLEN-1:0]   lo_reg, lo_next;        // multiplier-low half / quotient
    logic [XLEN-1:0]   mcand_reg, mcand_next;  // multiplicand or divisor magnitude
    logic              neg_reg, neg_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [XLEN-1:0]   resp_data_reg, resp_data_next;

    logic              signed_a;
    logic              signed_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              carry;
    logic [XLEN:0]     shifted;
    logic              qbit;
    logic [2*XLEN-1:0] prod_neg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= OP_MUL;
            hi_reg        <= '0;
            lo_reg        <= '0;
            mcand_reg     <= '0;
            neg_reg       <= 1'b0;
            cnt_reg       <= '0;
            resp_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            mcand_reg     <= mcand_next;
            neg_reg       <= neg_next;
            cnt_reg       <= cnt_next;
            resp_data_reg <= resp_data_next;
        end
    end

    // Operand sign handling for the request currently being offered.
    always_comb begin
        signed_a = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                   (req_op == OP_DIV)  || (req_op == OP_REM);
        signed_b = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        a_neg    = signed_a && req_a[XLEN-1];
        b_neg    = signed_b && req_b[XLEN-1];
        abs_a    = a_neg ? -req_a : req_a;
        abs_b    = b_neg ? -req_b : req_b;
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        mcand_next     = mcand_reg;
        neg_next       = neg_reg;
        cnt_next       = cnt_reg;
        resp_data_next = resp_data_reg;

        alu_grant = 1'b0;
        alu_func  = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;

        carry    = 1'b0;
        shifted  = {hi_reg, lo_reg[XLEN-1]};
        qbit     = 1'b0;
        prod_neg = -{hi_reg, lo_reg};

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_next = req_op;
                    if (req_op[2] && (req_b == '0)) begin
                        // Division by zero: all-ones quotient, remainder is the dividend.
                        resp_data_next = req_op[1] ? req_a : '1;
                        state_next     = DONE;
                    end else if (((req_op == OP_DIV) || (req_op == OP_REM)) &&
                                 (req_a == INT_MIN) && (req_b == '1)) begin
                        resp_data_next = req_op[1] ? '0 : INT_MIN;
                        state_next     = DONE;
                    end else begin
                        // Same register layout serves both algorithms.
                        hi_next    = '0;
                        lo_next    = abs_a;
                        mcand_next = abs_b;
                        neg_next   = (req_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                        cnt_next   = '0;
                        state_next = ITER;
                    end
                end
            end

            ITER: begin
                alu_grant = 1'b1;
                if (!op_reg[2]) begin
                    alu_func = ALU_ADD;
                    alu_a    = hi_reg;
                    alu_b    = lo_reg[0] ? mcand_reg : '0;
                    carry    = (alu_out < hi_reg);
                    {hi_next, lo_next} = {carry, alu_out, lo_reg[XLEN-1:1]};
                end else begin
                    // The ALU computes src_b - src_a, so the divisor goes on src_a.
                    alu_func = ALU_SUB;
                    alu_a    = mcand_reg;
                    alu_b    = shifted[XLEN-1:0];
                    qbit     = shifted[XLEN] || (shifted[XLEN-1:0] >= mcand_reg);
                    hi_next  = qbit ? alu_out : shifted[XLEN-1:0];
                    lo_next  = {lo_reg[XLEN-2:0], qbit};
                end
                cnt_next = cnt_reg + CNT_ONE;
                if (cnt_reg == CNT_LAST) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                case (op_reg)
                    OP_MUL:                      resp_data_next = lo_reg;
                    OP_MULH, OP_MULHSU, OP_MULHU:
                        resp_data_next = neg_reg ? prod_neg[2*XLEN-1:XLEN] : hi_reg;
                    OP_DIV, OP_DIVU:             resp_data_next = neg_reg ? -lo_reg : lo_reg;
                    default:                     resp_data_next = neg_reg ? -hi_reg : hi_reg;
                endcase
                state_next = DONE;
            end

            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == DONE);
    assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against a plain-arithmetic RV32M
// reference model, with a behavioural model of the shared ALU.
module tb_muldiv_seq;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        alu_grant;
    logic [3:0]  alu_func;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;

    int tests_run;
    int tests_failed;

    muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .alu_grant (alu_grant),
        .alu_func  (alu_func),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: SUB yields src_b - src_a.
    always_comb begin
        alu_out = (alu_func == ALU_SUB) ? (alu_b - alu_a) : (alu_a + alu_b);
    end

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        longint     q;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        q  = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
            3'd6: begin
                if (b == 32'd0) return a;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 32'd0) ? a : (a % b);
        endcase
    endfunction

    // Offers one request and waits (bounded) for the response; does not consume it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output int lat, output int grants,
                         output bit alu_idle_ok);
        int n;
        alu_idle_ok = 1'b1;
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat    = 1;
        grants = 0;
        while (!resp_valid && lat < 100) begin
            if (alu_grant) grants++;
            else if (alu_func != ALU_ADD || alu_a != 32'd0 || alu_b != 32'd0) alu_idle_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        data = resp_data;
        $display("[TB] op=%0d a=%h b=%h data=%h lat=%0d grants=%0d", op, a, b, data, lat, grants);
    endtask

    task automatic consume();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || alu_grant !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: ready=%b valid=%b grant=%b required 1 0 0",
                     req_ready, resp_valid, alu_grant);
        end
        tests_run++;
        if (resp_data !== 32'd0 || alu_func !== ALU_ADD || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_values: data=%h func=%0d a=%h b=%h required all zero",
                     resp_data, alu_func, alu_a, alu_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [12] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [12] = '{32'h0000_002A, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int          lats[12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
        logic [31:0] data;
        int          lat;
        int          grants;
        bit          idle_ok;
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i], data, lat, grants, idle_ok);
            tests_run++;
            if (data !== exp[i]) begin
                tests_failed++;
                $display("FAIL directed_data[%0d]: got %h expected %h", i, data, exp[i]);
            end
            tests_run++;
            if (lat != lats[i] || grants != ((lats[i] == 34) ? 32 : 0)) begin
                tests_failed++;
                $display("FAIL directed_timing[%0d]: lat=%0d grants=%0d expected lat=%0d grants=%0d",
                         i, lat, grants, lats[i], (lats[i] == 34) ? 32 : 0);
            end
            tests_run++;
            if (!idle_ok) begin
                tests_failed++;
                $display("FAIL directed_alu_idle[%0d]: ALU drive nonzero while not granted got 0 expected 1", i);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
        int          grants;
        int          exp_lat;
        bit          idle_ok;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exp = ref_model(op, a, b);
            exp_lat = (op[2] && (b == 32'd0 ||
                       (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            issue(op, a, b, data, lat, grants, idle_ok);
            tests_run++;
            if (data !== exp || lat != exp_lat) begin
                tests_failed++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d",
                         i, op, a, b, data, lat, exp, exp_lat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] data;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          grants;
        bit          idle_ok;
        bit          stable;
        a = $urandom;
        b = $urandom;
        issue(3'd0, a, b, data, lat, grants, idle_ok);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) begin
                req_op    = 3'd5;
                req_a     = 32'd9;
                req_b     = 32'd0;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            if (resp_valid !== 1'b1 || resp_data !== data || req_ready !== 1'b0) stable = 1'b0;
        end
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (!stable || data !== a * b) begin
            tests_failed++;
            $display("FAIL backpressure_hold: data=%h stable=%b expected %h stable 1",
                     data, stable, a * b);
        end
        consume();
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || alu_grant !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_ignored_req: valid=%b ready=%b grant=%b required 0 1 0",
                         resp_valid, req_ready, alu_grant);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] data;
        int          lat;
        int          grants;
        bit          idle_ok;
        @(negedge clk);
        req_op    = 3'd0;
        req_a     = 32'd1234;
        req_b     = 32'd5678;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (alu_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_busy: grant=%b required 1", alu_grant);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || alu_grant !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_idle: ready=%b valid=%b grant=%b required 1 0 0",
                     req_ready, resp_valid, alu_grant);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd0, 32'd3, 32'd3, data, lat, grants, idle_ok);
        tests_run++;
        if (data !== 32'd9 || lat != 34) begin
            tests_failed++;
            $display("FAIL midreset_followup: got %h lat %0d expected 00000009 lat 34", data, lat);
        end
        consume();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_a        = 32'd0;
        req_b        = 32'd0;
        resp_ready   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
